// File: rtl/seven_seg_pkg.sv
// Shared definitions for the seven-segment capture path: segment bit order,
// the sixteen hex glyph patterns and the digit-pair FSM state type.
package seven_seg_pkg;

  // Segment bus layout: bit0=a ... bit6=g, with the digit select above the segments
  localparam int SEG_W   = 7;
  localparam int SEL_BIT = SEG_W;

  typedef enum logic [2:0] {
    SEG_A = 3'd0,
    SEG_B = 3'd1,
    SEG_C = 3'd2,
    SEG_D = 3'd3,
    SEG_E = 3'd4,
    SEG_F = 3'd5,
    SEG_G = 3'd6
  } seg_bit_t;

  // Active-high glyph patterns for the hex digits 0..F
  localparam logic [SEG_W-1:0] GLYPH_0 = 7'h3F;
  localparam logic [SEG_W-1:0] GLYPH_1 = 7'h06;
  localparam logic [SEG_W-1:0] GLYPH_2 = 7'h5B;
  localparam logic [SEG_W-1:0] GLYPH_3 = 7'h4F;
  localparam logic [SEG_W-1:0] GLYPH_4 = 7'h66;
  localparam logic [SEG_W-1:0] GLYPH_5 = 7'h6D;
  localparam logic [SEG_W-1:0] GLYPH_6 = 7'h7D;
  localparam logic [SEG_W-1:0] GLYPH_7 = 7'h07;
  localparam logic [SEG_W-1:0] GLYPH_8 = 7'h7F;
  localparam logic [SEG_W-1:0] GLYPH_9 = 7'h6F;
  localparam logic [SEG_W-1:0] GLYPH_A = 7'h77;
  localparam logic [SEG_W-1:0] GLYPH_B = 7'h7C;
  localparam logic [SEG_W-1:0] GLYPH_C = 7'h39;
  localparam logic [SEG_W-1:0] GLYPH_D = 7'h5E;
  localparam logic [SEG_W-1:0] GLYPH_E = 7'h79;
  localparam logic [SEG_W-1:0] GLYPH_F = 7'h71;

  // Upper digit seen and waiting for its lower partner, or idle
  typedef enum logic {
    WAIT_HI = 1'b0,
    GOT_HI  = 1'b1
  } pair_state_t;

  // Glyph pattern the driver side emits for a given nibble
  function automatic logic [SEG_W-1:0] glyph_of(input logic [3:0] nib);
    logic [SEG_W-1:0] g;
    case (nib)
      4'h0: g = GLYPH_0;
      4'h1: g = GLYPH_1;
      4'h2: g = GLYPH_2;
      4'h3: g = GLYPH_3;
      4'h4: g = GLYPH_4;
      4'h5: g = GLYPH_5;
      4'h6: g = GLYPH_6;
      4'h7: g = GLYPH_7;
      4'h8: g = GLYPH_8;
      4'h9: g = GLYPH_9;
      4'hA: g = GLYPH_A;
      4'hB: g = GLYPH_B;
      4'hC: g = GLYPH_C;
      4'hD: g = GLYPH_D;
      4'hE: g = GLYPH_E;
      default: g = GLYPH_F;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/seg_glyph_decode.sv
// Turns a captured seven-segment pattern back into the hex nibble it shows.
// Patterns that are not one of the sixteen glyphs (blank included) read as
// zero with ok low.
module seg_glyph_decode
  import seven_seg_pkg::*;
(
  input  logic [SEG_W-1:0] pattern,
  output logic [3:0]       hex,
  output logic             ok
);

  // Search the glyph table; glyphs are unique so at most one entry matches
  always_comb begin
    hex = 4'h0;
    ok  = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (pattern == glyph_of(4'(i))) begin
        hex = 4'(i);
        ok  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/seven_seg_capture.sv
// Receive side of the two-digit multiplexed seven-segment bus: synchronizes
// the bus, waits for each digit phase to settle, rebuilds the 14-bit word,
// pairs upper/lower digits into frames and flags a bus that has gone quiet.
module seven_seg_capture
  import seven_seg_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int TIMEOUT       = 40000,
  parameter int TBITS         = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [SEG_W-1:0]     seg_in,
  input  logic                 digit_sel_in,
  output logic [2*SEG_W-1:0]   both7seg_out,
  output logic [3:0]           hex_hi,
  output logic [3:0]           hex_lo,
  output logic                 ok_hi,
  output logic                 ok_lo,
  output logic                 frame_valid,
  output logic                 stale
);

  localparam logic [7:0]       STABLE_C  = 8'(STABLE_CYCLES);
  localparam logic [TBITS-1:0] TIMEOUT_C = TBITS'(TIMEOUT);

  logic [SEG_W:0]       sync1_q, sync1_d;
  logic [SEG_W:0]       sync2_q, sync2_d;
  logic [SEG_W:0]       prev_q, prev_d;
  logic [SEG_W:0]       committed_q, committed_d;
  logic [7:0]           run_q, run_d;
  logic [2*SEG_W-1:0]   word_q, word_d;
  logic [TBITS-1:0]     idle_q, idle_d;
  logic [SEG_W:0]       samp;
  logic                 commit;
  pair_state_t          state_q;
  logic                 frame_valid_q;

  // Two-flop synchronizer input for the select strobe and segment lines together
  always_comb begin
    sync1_d = {digit_sel_in, seg_in};
    sync2_d = sync1_q;
  end

  // Run-length stability filter, commit routing into the word and idle counting
  always_comb begin
    samp   = sync2_q;
    prev_d = samp;
    if (samp != prev_q) begin
      run_d = 8'd1;
    end else if (run_q != STABLE_C) begin
      run_d = run_q + 8'd1;
    end else begin
      run_d = run_q;
    end

    commit      = (run_d == STABLE_C) && (samp != committed_q);
    committed_d = commit ? samp : committed_q;

    word_d = word_q;
    if (commit) begin
      if (samp[SEL_BIT]) begin
        word_d[2*SEG_W-1:SEG_W] = samp[SEG_W-1:0];
      end else begin
        word_d[SEG_W-1:0] = samp[SEG_W-1:0];
      end
    end

    if (commit) begin
      idle_d = '0;
    end else if (idle_q != TIMEOUT_C) begin
      idle_d = idle_q + TBITS'(1);
    end else begin
      idle_d = idle_q;
    end
  end

  // Datapath registers with synchronous reset; a reset drops any run in progress
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      prev_q      <= '0;
      committed_q <= '0;
      run_q       <= '0;
      word_q      <= '0;
      idle_q      <= '0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      prev_q      <= prev_d;
      committed_q <= committed_d;
      run_q       <= run_d;
      word_q      <= word_d;
      idle_q      <= idle_d;
    end
  end

  // Pair FSM: a lower commit that follows an upper commit completes a frame
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= WAIT_HI;
      frame_valid_q <= 1'b0;
    end else begin
      frame_valid_q <= 1'b0;
      case (state_q)
        WAIT_HI: begin
          if (commit && samp[SEL_BIT]) begin
            state_q <= GOT_HI;
          end
        end
        GOT_HI: begin
          if (commit && !samp[SEL_BIT]) begin
            frame_valid_q <= 1'b1;
            state_q       <= WAIT_HI;
          end
        end
        default: state_q <= WAIT_HI;
      endcase
    end
  end

  seg_glyph_decode u_dec_hi (
    .pattern (word_q[2*SEG_W-1:SEG_W]),
    .hex     (hex_hi),
    .ok      (ok_hi)
  );

  seg_glyph_decode u_dec_lo (
    .pattern (word_q[SEG_W-1:0]),
    .hex     (hex_lo),
    .ok      (ok_lo)
  );

  assign both7seg_out = word_q;
  assign frame_valid  = frame_valid_q;
  assign stale        = (idle_q == TIMEOUT_C);

endmodule

// File: tb/tb_seven_seg_capture.sv
// Self-checking bench for seven_seg_capture: directed scenarios followed by
// randomized bus activity, all compared against a behavioural reference model.
module tb_seven_seg_capture;

  localparam int STABLE = 4;
  localparam int TOUT   = 100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [6:0]  seg_drv = 7'h00;
  logic        sel_drv = 1'b0;
  logic [13:0] both7seg_out;
  logic [3:0]  hex_hi, hex_lo;
  logic        ok_hi, ok_lo, frame_valid, stale;

  int n_checks = 0;
  int n_fail   = 0;
  int pulses_seen = 0;

  // Reference model state
  logic [7:0] dly[$];
  logic [7:0] hist[$];
  logic [7:0] m_comm;
  logic [6:0] m_hi, m_lo;
  bit         m_got_hi;
  bit         m_fv;
  int         m_since;

  logic [6:0] glyphs [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  seven_seg_capture #(
    .STABLE_CYCLES (STABLE),
    .TIMEOUT       (TOUT),
    .TBITS         (16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .seg_in       (seg_drv),
    .digit_sel_in (sel_drv),
    .both7seg_out (both7seg_out),
    .hex_hi       (hex_hi),
    .hex_lo       (hex_lo),
    .ok_hi        (ok_hi),
    .ok_lo        (ok_lo),
    .frame_valid  (frame_valid),
    .stale        (stale)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // {ok, hex} for a pattern, found by table lookup
  function automatic logic [4:0] refDecode(input logic [6:0] p);
    logic [4:0] r;
    r = 5'h00;
    for (int i = 0; i < 16; i++) begin
      if (glyphs[i] == p) r = {1'b1, 4'(i)};
    end
    return r;
  endfunction

  // One clock edge of the reference: the bus value seen two edges late, committed
  // once the last STABLE samples agree and differ from the last committed value
  task automatic modelStep(input logic r, input logic [7:0] drv);
    logic [7:0] samp;
    bit         steady;
    if (r) begin
      dly = '{8'h00, 8'h00};
      hist.delete();
      m_comm = 8'h00; m_hi = 7'h00; m_lo = 7'h00;
      m_got_hi = 1'b0; m_fv = 1'b0; m_since = 0;
      return;
    end
    samp = dly.pop_front();
    dly.push_back(drv);
    hist.push_back(samp);
    if (hist.size() > STABLE) void'(hist.pop_front());
    steady = (hist.size() == STABLE);
    foreach (hist[i]) if (hist[i] != samp) steady = 1'b0;
    m_fv = 1'b0;
    if (steady && samp != m_comm) begin
      m_comm = samp;
      if (samp[7]) begin
        m_hi = samp[6:0];
        m_got_hi = 1'b1;
      end else begin
        m_lo = samp[6:0];
        m_fv = m_got_hi;
        m_got_hi = 1'b0;
      end
      m_since = 0;
    end else if (m_since < TOUT) begin
      m_since++;
    end
  endtask

  // Hold the given bus value (and reset) for n cycles, checking every cycle
  task automatic applyStimulus(input logic r, input logic sel, input logic [6:0] seg, input int n);
    logic [4:0] dh, dl;
    repeat (n) begin
      @(negedge clk);
      rst = r; sel_drv = sel; seg_drv = seg;
      @(posedge clk);
      modelStep(r, {sel, seg});
      #1;
      dh = refDecode(m_hi);
      dl = refDecode(m_lo);
      checkOutput("both7seg", 32'(both7seg_out), 32'({m_hi, m_lo}));
      checkOutput("hex_hi", 32'(hex_hi), 32'(dh[3:0]));
      checkOutput("hex_lo", 32'(hex_lo), 32'(dl[3:0]));
      checkOutput("ok_hi", 32'(ok_hi), 32'(dh[4]));
      checkOutput("ok_lo", 32'(ok_lo), 32'(dl[4]));
      checkOutput("frame_valid", 32'(frame_valid), 32'(m_fv));
      checkOutput("stale", 32'(stale), 32'(m_since == TOUT));
      if (frame_valid === 1'b1) pulses_seen++;
    end
  endtask

  initial begin
    int p0;
    logic r;
    logic sel;
    logic [6:0] seg;

    // Reset state
    applyStimulus(1'b1, 1'b0, 7'h00, 2);
    checkOutput("reset_word", 32'(both7seg_out), 32'h0);
    checkOutput("reset_stale", 32'(stale), 32'h0);

    // Upper 4 then lower 5 forms one frame
    p0 = pulses_seen;
    applyStimulus(1'b0, 1'b1, 7'h66, 10);
    applyStimulus(1'b0, 1'b0, 7'h6D, 5);
    checkOutput("pair_no_early_pulse", 32'(pulses_seen - p0), 32'h0);
    applyStimulus(1'b0, 1'b0, 7'h6D, 1);
    checkOutput("pair_pulse_at_5", 32'(frame_valid), 32'h1);
    applyStimulus(1'b0, 1'b0, 7'h6D, 4);
    checkOutput("pair_word", 32'(both7seg_out), 32'h336D);
    checkOutput("pair_hex_hi", 32'(hex_hi), 32'h4);
    checkOutput("pair_hex_lo", 32'(hex_lo), 32'h5);
    checkOutput("pair_ok", 32'({ok_hi, ok_lo}), 32'h3);
    checkOutput("pair_pulses", 32'(pulses_seen - p0), 32'h1);

    // Short glitch on a stable upper digit is ignored
    applyStimulus(1'b0, 1'b1, 7'h3F, 10);
    applyStimulus(1'b0, 1'b1, 7'h7F, 2);
    applyStimulus(1'b0, 1'b1, 7'h3F, 10);
    checkOutput("glitch_word", 32'(both7seg_out), 32'({7'h3F, 7'h6D}));

    // Upper overwritten before the lower arrives: single pulse on the lower
    p0 = pulses_seen;
    applyStimulus(1'b0, 1'b1, 7'h5B, 10);
    applyStimulus(1'b0, 1'b1, 7'h4F, 10);
    checkOutput("overwrite_no_pulse", 32'(pulses_seen - p0), 32'h0);
    applyStimulus(1'b0, 1'b0, 7'h06, 10);
    checkOutput("overwrite_upper", 32'(both7seg_out[13:7]), 32'h4F);
    checkOutput("overwrite_hex_lo", 32'(hex_lo), 32'h1);
    checkOutput("overwrite_pulses", 32'(pulses_seen - p0), 32'h1);

    // Illegal lower pattern while waiting for an upper digit
    p0 = pulses_seen;
    applyStimulus(1'b0, 1'b0, 7'h12, 10);
    checkOutput("illegal_lo_bits", 32'(both7seg_out[6:0]), 32'h12);
    checkOutput("illegal_hex_lo", 32'(hex_lo), 32'h0);
    checkOutput("illegal_ok_lo", 32'(ok_lo), 32'h0);
    checkOutput("illegal_no_pulse", 32'(pulses_seen - p0), 32'h0);

    // Quiet bus goes stale; the next commit clears it on its own edge
    applyStimulus(1'b0, 1'b0, 7'h12, 100);
    checkOutput("stale_set", 32'(stale), 32'h1);
    applyStimulus(1'b0, 1'b1, 7'h06, 5);
    checkOutput("stale_held", 32'(stale), 32'h1);
    applyStimulus(1'b0, 1'b1, 7'h06, 1);
    checkOutput("stale_cleared", 32'(stale), 32'h0);
    checkOutput("stale_commit_hex_hi", 32'(hex_hi), 32'h1);

    // Reset in GOT_HI with a lower digit part-way through its run
    applyStimulus(1'b0, 1'b0, 7'h3F, 4);
    applyStimulus(1'b1, 1'b0, 7'h3F, 1);
    checkOutput("midreset_word", 32'(both7seg_out), 32'h0);
    applyStimulus(1'b0, 1'b0, 7'h3F, 5);
    checkOutput("midreset_no_early", 32'(both7seg_out), 32'h0);
    applyStimulus(1'b0, 1'b0, 7'h3F, 1);
    checkOutput("midreset_commit", 32'(both7seg_out), 32'h3F);
    checkOutput("midreset_no_pulse", 32'(frame_valid), 32'h0);

    // Randomized bus activity: mostly glyphs, some arbitrary patterns, varied
    // hold times so that some phases are too short to commit, rare resets
    for (int k = 0; k < 160; k++) begin
      r   = ($urandom_range(0, 40) == 0);
      sel = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) seg = 7'($urandom);
      else                           seg = glyphs[$urandom_range(0, 15)];
      applyStimulus(r, sel, seg, r ? 1 : int'($urandom_range(1, 9)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
